mem_port_arbiter: RTL

- Shares the core's single-port unified memory between the instruction-fetch unit (read-only) and the load/store unit (read/write).
- Sits between the core pipeline and the memory/IO bus.
- Arbitrates pending requests, runs one memory transaction at a time with a valid/ack handshake, and returns read data or a write completion to the owning requester.

---
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction
// fetch unit (read-only, i_*) and the load/store unit (read/write, d_*).
// Round-robin arbitration on contention. One memory transaction at a time
// over a mem_req/mem_ack handshake. The owner gets a one-cycle *_rvalid.
//
// Ports:
//   clock, reset                 clock and asynchronous active-high reset
//   i_req/i_addr                 fetch request (held until i_gnt)
//   i_gnt/i_rvalid/i_rdata/i_err fetch grant, response, data, timeout flag
//   d_req/d_we/d_addr/d_wdata/d_wstrb  data request fields
//   d_gnt/d_rvalid/d_rdata/d_err       data grant, response, data, timeout flag
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb  memory transaction outputs
//   mem_rdata/mem_ack            memory read data and completion
//
// Optional build macro MEM_ARB_TIMEOUT_EN: BUSY watchdog of TIMEOUT_CYCLES.
// When the watchdog fires, the owner gets a response with *_err=1 and *_rdata=0.
// When the macro is undefined, BUSY waits indefinitely and *_err are tied to 0.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t              r_state, w_next;
  owner_t              r_owner, r_last_owner, w_pick;
  logic                r_we, r_first;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata, r_i_rdata, r_d_rdata, w_cap;
  logic [DATA_W/8-1:0] r_wstrb;
  logic                w_take, w_done, w_timeout;

  // Contention goes to whoever did not own the previous transaction.
  assign w_pick = (d_req && (!i_req || r_last_owner == OWN_I)) ? OWN_D : OWN_I;
  assign w_take = (r_state == S_IDLE || r_state == S_RESP) && (i_req || d_req);
  assign w_done = (r_state == S_BUSY) && (mem_ack || w_timeout);
  // A write returns 0. A timeout also returns 0, because mem_ack is low then.
  assign w_cap  = (mem_ack && !r_we) ? mem_rdata : '0;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // An ack in the cycle the limit is reached wins over the timeout.
  assign w_timeout = (r_state == S_BUSY) && !mem_ack &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_take)
        r_cnt <= '0;
      else if (r_state == S_BUSY && !mem_ack)
        r_cnt <= r_cnt + 1'b1;
      if (w_done)
        r_err <= w_timeout;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_RESP: w_next = (i_req || d_req) ? S_BUSY : S_IDLE;
      S_BUSY:         if (mem_ack || w_timeout) w_next = S_RESP;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_owner      <= OWN_I;
      r_last_owner <= OWN_I;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_first      <= 1'b0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
    end else begin
      r_first <= w_take;
      if (w_take) begin
        r_owner      <= w_pick;
        r_last_owner <= w_pick;
        if (w_pick == OWN_D) begin
          r_we    <= d_we;
          r_addr  <= d_addr;
          r_wdata <= d_wdata;
          r_wstrb <= d_we ? d_wstrb : '0;
        end else begin
          r_we    <= 1'b0;
          r_addr  <= i_addr;
          r_wdata <= '0;
          r_wstrb <= '0;
        end
      end
      if (w_done) begin
        if (r_owner == OWN_D)
          r_d_rdata <= w_cap;
        else
          r_i_rdata <= w_cap;
      end
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    i_err     = 1'b0;
    d_err     = 1'b0;
    unique case (r_state)
      S_BUSY: begin
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        mem_wstrb = r_wstrb;
        i_gnt     = r_first && (r_owner == OWN_I);
        d_gnt     = r_first && (r_owner == OWN_D);
      end
      S_RESP: begin
        i_rvalid = (r_owner == OWN_I);
        d_rvalid = (r_owner == OWN_D);
`ifdef MEM_ARB_TIMEOUT_EN
        i_err    = r_err && (r_owner == OWN_I);
        d_err    = r_err && (r_owner == OWN_D);
`endif
      end
      default: ;
    endcase
  end

  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;

endmodule
